// File: rtl/csum_pkg.sv
// Shared types and arithmetic helpers for the packet checksum checker.
package csum_pkg;

    typedef struct packed {
        logic        match;
        logic        short_pkt;
        logic [15:0] expected;
        logic [15:0] computed;
    } csum_result_t;

    // Derived geometry, evaluated from each instance's own parameters.
    function automatic int csum_lanes(input int data_w);
        return data_w / 16;
    endfunction

    function automatic int csum_beat_cnt_w(input int csum_beat);
        return $clog2(csum_beat + 2);
    endfunction

    // Two end-around-carry folds are enough to bring any 32-bit sum to 16 bits.
    function automatic logic [15:0] csum_fold(input logic [31:0] a);
        logic [16:0] s1;
        logic [15:0] s2;
        s1 = {1'b0, a[15:0]} + {1'b0, a[31:16]};
        s2 = s1[15:0] + {15'h0, s1[16]};
        return s2;
    endfunction

    function automatic logic [15:0] byte_swap16(input logic [15:0] a);
        return {a[7:0], a[15:8]};
    endfunction

endpackage

// File: rtl/csum_check_multi_if.sv
// Tapped stream beat bus plus the verdict valid/ready port of the checksum checker.
interface csum_check_multi_if #(
    parameter int DATA_W = 64
);
    logic                  s_axi_valid;
    logic [DATA_W-1:0]     s_axi_data;
    logic [DATA_W/8-1:0]   s_axi_keep;
    logic                  s_axi_last;
    logic                  s_axi_ready;

    logic                  m_res_valid;
    logic                  m_res_ready;
    logic                  m_res_match;
    logic                  m_res_short;
    logic [15:0]           m_res_expected;
    logic [15:0]           m_res_computed;

    modport master (
        output s_axi_valid, s_axi_data, s_axi_keep, s_axi_last, s_axi_ready,
        output m_res_ready,
        input  m_res_valid, m_res_match, m_res_short, m_res_expected, m_res_computed
    );

    modport slave (
        input  s_axi_valid, s_axi_data, s_axi_keep, s_axi_last, s_axi_ready,
        input  m_res_ready,
        output m_res_valid, m_res_match, m_res_short, m_res_expected, m_res_computed
    );
endinterface

// File: rtl/csum_result_fifo.sv
// Synchronous first-word-fall-through FIFO of checksum verdicts.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: a push while full is refused unless a pop happens in the same cycle.
module csum_result_fifo
    import csum_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         push,
    input  csum_result_t push_dat,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output csum_result_t head
);
    localparam int AW = $clog2(DEPTH);

    csum_result_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/csum_check_multi.sv
// Passive per-packet ones-complement checksum checker tapping a beat stream.
// Latency: verdict written at T+2 after the last-beat handshake, visible at T+3.
// Backpressure: never stalls the stream; verdicts arriving at a full FIFO are dropped and counted.
module csum_check_multi
    import csum_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int CSUM_BEAT  = 6,
    parameter int CSUM_LANE  = 1,
    parameter bit SWAP_BYTES = 1'b1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             areset,
    csum_check_multi_if.slave bus,
    output logic             pkt_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int LANES      = csum_lanes(DATA_W);
    localparam int BEAT_CNT_W = csum_beat_cnt_w(CSUM_BEAT);
    localparam logic [BEAT_CNT_W-1:0] BEAT_CS  = BEAT_CNT_W'(CSUM_BEAT);
    localparam logic [BEAT_CNT_W-1:0] BEAT_SAT = BEAT_CNT_W'(CSUM_BEAT + 1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                state;
    logic [BEAT_CNT_W-1:0] bcnt;
    logic [31:0]           acc;
    logic [15:0]           exp_q;

    logic                  beat_acc;
    logic                  first;
    logic                  at_cs;
    logic [DATA_W-1:0]     masked;
    logic [31:0]           beat_sum;
    logic [15:0]           cs_word;
    logic [32:0]           acc_sum;
    logic [31:0]           acc_next;
    logic [15:0]           exp_next;
    logic [15:0]           fold_inv;
    logic [15:0]           computed_c;
    logic                  short_c;

    assign beat_acc = bus.s_axi_valid & bus.s_axi_ready;
    assign first    = (state == IDLE);
    assign at_cs    = (bcnt == BEAT_CS);

    always_comb begin
        masked   = '0;
        beat_sum = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            masked[8*b +: 8] = bus.s_axi_keep[b] ? bus.s_axi_data[8*b +: 8] : 8'h00;
        end
        cs_word = masked[16*CSUM_LANE +: 16];
        for (int i = 0; i < LANES; i++) begin
            if (!(at_cs && i == CSUM_LANE)) beat_sum = beat_sum + {16'h0, masked[16*i +: 16]};
        end
    end

    // Carry out of the running sum is wrapped back in so long packets stay exact.
    assign acc_sum    = {1'b0, acc} + {1'b0, beat_sum};
    assign acc_next   = first ? beat_sum : (acc_sum[31:0] + {31'h0, acc_sum[32]});
    assign exp_next   = at_cs ? cs_word : (first ? 16'h0 : exp_q);
    assign fold_inv   = ~csum_fold(acc_next);
    assign computed_c = SWAP_BYTES ? byte_swap16(fold_inv) : fold_inv;
    assign short_c    = (bcnt < BEAT_CS);

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
            bcnt  <= '0;
            acc   <= '0;
            exp_q <= '0;
        end else if (beat_acc) begin
            acc   <= acc_next;
            exp_q <= exp_next;
            if (bus.s_axi_last) begin
                state <= IDLE;
                bcnt  <= '0;
            end else begin
                state <= IN_PKT;
                if (bcnt != BEAT_SAT) bcnt <= bcnt + 1'b1;
            end
        end
    end

    logic         s1_vld;
    logic [15:0]  s1_comp;
    logic [15:0]  s1_exp;
    logic         s1_short;
    logic         s1_match;
    logic         s2_vld;
    csum_result_t s2_res;

    assign s1_match = !s1_short && (s1_exp == s1_comp);

    always_ff @(posedge clk) begin
        if (areset) begin
            s1_vld   <= 1'b0;
            s1_comp  <= '0;
            s1_exp   <= '0;
            s1_short <= 1'b0;
            s2_vld   <= 1'b0;
            s2_res   <= '0;
            pkt_err  <= 1'b0;
        end else begin
            s1_vld <= beat_acc & bus.s_axi_last;
            if (beat_acc && bus.s_axi_last) begin
                s1_comp  <= computed_c;
                s1_exp   <= exp_next;
                s1_short <= short_c;
            end
            s2_vld  <= s1_vld;
            pkt_err <= s1_vld & ~s1_match;
            if (s1_vld) begin
                s2_res.match     <= s1_match;
                s2_res.short_pkt <= s1_short;
                s2_res.expected  <= s1_exp;
                s2_res.computed  <= s1_comp;
            end
        end
    end

    logic         fifo_full;
    logic         fifo_empty;
    logic         res_pop;
    csum_result_t head;

    assign res_pop = ~fifo_empty & bus.m_res_ready;

    csum_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .areset   (areset),
        .push     (s2_vld),
        .push_dat (s2_res),
        .full     (fifo_full),
        .pop      (res_pop),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign bus.m_res_valid    = ~fifo_empty;
    assign bus.m_res_match    = head.match;
    assign bus.m_res_short    = head.short_pkt;
    assign bus.m_res_expected = head.expected;
    assign bus.m_res_computed = head.computed;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && c != '1) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk) begin
        if (areset || clr_cnt) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            good_cnt <= sat_inc(good_cnt, s2_vld &  s2_res.match);
            bad_cnt  <= sat_inc(bad_cnt,  s2_vld & ~s2_res.match);
            drop_cnt <= sat_inc(drop_cnt, s2_vld & fifo_full & ~res_pop);
        end
    end

endmodule

// File: tb/tb_csum_check_multi.sv
// Directed bench for csum_check_multi with hand-computed verdicts and counter values.
module tb_csum_check_multi;
    import csum_pkg::*;

    logic        clk = 1'b0;
    logic        areset;
    logic        pkt_err;
    logic        clr_cnt;
    logic [63:0] good_cnt;
    logic [63:0] bad_cnt;
    logic [63:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    csum_check_multi_if #(.DATA_W(64)) bus ();

    always #5 clk = ~clk;

    csum_check_multi #(
        .DATA_W(64), .CSUM_BEAT(6), .CSUM_LANE(1), .SWAP_BYTES(1'b1),
        .FIFO_DEPTH(16), .CNT_W(64)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .bus      (bus.slave),
        .pkt_err  (pkt_err),
        .clr_cnt  (clr_cnt),
        .good_cnt (good_cnt),
        .bad_cnt  (bad_cnt),
        .drop_cnt (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bus.s_axi_valid = 1'b1;
        bus.s_axi_data  = d;
        bus.s_axi_keep  = k;
        bus.s_axi_last  = l;
        next_cyc();
    endtask

    task automatic drop_valid();
        bus.s_axi_valid = 1'b0;
        bus.s_axi_last  = 1'b0;
        bus.s_axi_data  = '0;
    endtask

    // Beat 0 carries b0/k0, beat 6 lane 1 carries the embedded field, the rest are zero.
    task automatic send_pkt(input int n, input logic [63:0] b0, input logic [7:0] k0, input logic [15:0] ew);
        logic [63:0] d;
        logic [7:0]  k;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? b0 : 64'h0;
            k = (i == 0) ? k0 : 8'hFF;
            if (i == 6) d = {32'h0, ew, 16'h0};
            beat(d, k, i == n - 1);
        end
    endtask

    task automatic pop_expect(input string tag, input logic m, input logic s,
                              input logic [15:0] e, input logic [15:0] c);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.m_res_valid), 64'h1);
        check({tag, "_fields"},
              64'({bus.m_res_match, bus.m_res_short, bus.m_res_expected, bus.m_res_computed}),
              64'({m, s, e, c}));
        bus.m_res_ready = 1'b1;
        next_cyc();
        bus.m_res_ready = 1'b0;
    endtask

    function automatic logic [15:0] swapped_inv(input int v);
        logic [15:0] c;
        c = ~16'(v);
        return {c[7:0], c[15:8]};
    endfunction

    initial begin
        areset          = 1'b1;
        clr_cnt         = 1'b0;
        bus.s_axi_ready = 1'b1;
        bus.s_axi_keep  = '0;
        bus.m_res_ready = 1'b0;
        drop_valid();
        repeat (3) next_cyc();
        areset = 1'b0;

        @(negedge clk);
        check("rst_valid", 64'(bus.m_res_valid), 64'h0);
        check("rst_fields", 64'({bus.m_res_match, bus.m_res_short, bus.m_res_expected, bus.m_res_computed}), 64'h0);
        check("rst_perr", 64'(pkt_err), 64'h0);
        check("rst_cnts", good_cnt | bad_cnt | drop_cnt, 64'h0);
        next_cyc();

        // Case 1: all-zero packet with 0xFFFF embedded; latency to m_res_valid.
        send_pkt(7, 64'h0, 8'hFF, 16'hFFFF);
        drop_valid();
        @(negedge clk);
        check("c1_valid_t1", 64'(bus.m_res_valid), 64'h0);
        next_cyc();
        @(negedge clk);
        check("c1_valid_t2", 64'(bus.m_res_valid), 64'h0);
        check("c1_perr_t2", 64'(pkt_err), 64'h0);
        next_cyc();
        @(negedge clk);
        check("c1_valid_t3", 64'(bus.m_res_valid), 64'h1);
        exp_good++;
        check("c1_good", good_cnt, 64'(exp_good));
        pop_expect("c1_res", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);

        // Case 2a: lane 0 = 1 gives ~0x0001 swapped = 0xFEFF.
        send_pkt(7, 64'h1, 8'hFF, 16'hFEFF);
        drop_valid();
        repeat (2) next_cyc();
        exp_good++;
        pop_expect("c2a_res", 1'b1, 1'b0, 16'hFEFF, 16'hFEFF);

        // Case 2b: wrong embedded value; pkt_err exactly at T+2.
        send_pkt(7, 64'h1, 8'hFF, 16'hFFFE);
        drop_valid();
        @(negedge clk);
        check("c2b_perr_t1", 64'(pkt_err), 64'h0);
        next_cyc();
        @(negedge clk);
        check("c2b_perr_t2", 64'(pkt_err), 64'h1);
        next_cyc();
        @(negedge clk);
        check("c2b_perr_t3", 64'(pkt_err), 64'h0);
        exp_bad++;
        check("c2b_bad", bad_cnt, 64'(exp_bad));
        pop_expect("c2b_res", 1'b0, 1'b0, 16'hFFFE, 16'hFEFF);

        // Case 3: short packet immediately followed by a good one.
        send_pkt(3, 64'h0, 8'hFF, 16'h0);
        send_pkt(7, 64'h0, 8'hFF, 16'hFFFF);
        drop_valid();
        repeat (3) next_cyc();
        exp_bad++;
        exp_good++;
        pop_expect("c3_short", 1'b0, 1'b1, 16'h0000, 16'hFFFF);
        pop_expect("c3_next", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        check("c3_bad", bad_cnt, 64'(exp_bad));

        // Case 4: only byte 0 kept, 0x00FF summed.
        send_pkt(7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 16'hFFFF);
        drop_valid();
        repeat (3) next_cyc();
        exp_bad++;
        pop_expect("c4_res", 1'b0, 1'b0, 16'hFFFF, 16'h00FF);
        check("c4_bad", bad_cnt, 64'(exp_bad));

        // Case 5: 18 good packets into a stalled 16-deep FIFO.
        for (int i = 0; i < 18; i++) send_pkt(7, 64'(i), 8'hFF, swapped_inv(i));
        drop_valid();
        repeat (4) next_cyc();
        exp_good += 18;
        @(negedge clk);
        check("c5_drop", drop_cnt, 64'h2);
        check("c5_good", good_cnt, 64'(exp_good));
        for (int i = 0; i < 16; i++) pop_expect($sformatf("c5_pop%0d", i), 1'b1, 1'b0, swapped_inv(i), swapped_inv(i));
        @(negedge clk);
        check("c5_empty", 64'(bus.m_res_valid), 64'h0);
        next_cyc();

        // Case 6: reset on beat 4 discards the partial packet.
        for (int i = 0; i < 4; i++) beat(64'h0, 8'hFF, 1'b0);
        areset = 1'b1;
        beat(64'h0, 8'hFF, 1'b0);
        areset = 1'b0;
        drop_valid();
        next_cyc();
        @(negedge clk);
        check("c6_rst_valid", 64'(bus.m_res_valid), 64'h0);
        check("c6_rst_cnts", good_cnt | bad_cnt | drop_cnt, 64'h0);
        next_cyc();
        send_pkt(7, 64'h0, 8'hFF, 16'hFFFF);
        drop_valid();
        repeat (3) next_cyc();
        @(negedge clk);
        check("c6_good", good_cnt, 64'h1);
        pop_expect("c6_res", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        check("c6_single", 64'(bus.m_res_valid), 64'h0);
        next_cyc();

        // clr_cnt coinciding with a good verdict's counter update.
        send_pkt(7, 64'h0, 8'hFF, 16'hFFFF);
        drop_valid();
        next_cyc();
        clr_cnt = 1'b1;
        next_cyc();
        clr_cnt = 1'b0;
        @(negedge clk);
        check("c6_clr_good", good_cnt, 64'h0);
        pop_expect("c6_clr_res", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csum_check_multi.md
Name: csum_check_multi

Overview:
- Passive checksum checker that taps an AXI-Stream beat interface; it does not drive the ready signal.
- Per packet, it computes the 16-bit ones-complement checksum over all kept bytes, with the embedded checksum field zeroed.
- It captures the embedded field at a parametrised beat and 16-bit lane and compares the two values.
- Each verdict is queued in an internal result FIFO drained by a valid/ready port. An error pulse and saturating statistics counters are also provided.
- This is the generalised successor of the fixed 64-bit, beat-6 checker in the crypto datapath, with the checksum computation absorbed into the block.

Parameters:
- DATA_W, 64: stream width; a multiple of 16, from 16 to 512.
- CSUM_BEAT, 6: zero-based beat index that holds the embedded checksum.
- CSUM_LANE, 1: 16-bit lane within that beat; lane i is data[16i+15:16i].
- SWAP_BYTES, 1: when 1, the computed checksum is byte-swapped before compare.
- FIFO_DEPTH, 16: result FIFO depth; a power of 2, at least 2.
- CNT_W, 64: width of the statistics counters.

Ports:
- clk  in  1  clock.
- areset  in  1  reset; synchronous, active-high.
- s_axi_valid  in  1  tapped stream valid.
- s_axi_data  in  DATA_W  tapped data.
- s_axi_keep  in  DATA_W/8  byte enables; byte b is data[8b+7:8b].
- s_axi_last  in  1  last beat of the packet.
- s_axi_ready  in  1  tapped ready; a beat counts only when valid and ready are both high.
- m_res_valid  out  1  result available.
- m_res_ready  in  1  result consumer ready.
- m_res_match  out  1  computed value equals expected and the packet was not short.
- m_res_short  out  1  packet ended before CSUM_BEAT.
- m_res_expected  out  16  captured embedded field.
- m_res_computed  out  16  computed checksum, after the optional swap.
- pkt_err  out  1  one-cycle pulse on each mismatch or short verdict.
- clr_cnt  in  1  synchronous clear of all counters.
- good_cnt  out  CNT_W  matching packets.
- bad_cnt  out  CNT_W  mismatching or short packets.
- drop_cnt  out  CNT_W  verdicts lost because the FIFO was full.

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, the beat counter is 0 and the accumulator is 0. Reset mid-packet discards the partial packet and produces no result.
- Beat counter: saturates at CSUM_BEAT+1.
  - State IDLE: counter is 0 and no packet is open.
  - State IN_PKT: entered on the first accepted beat without last.
  - Back to IDLE: on an accepted beat with last.
  - A single-beat packet stays in IDLE.
- Accumulation, per accepted beat:
  - Bytes with keep=0 are zeroed.
  - On beat CSUM_BEAT, the CSUM_LANE word is captured to the expected register and replaced by 0 before summing.
  - All DATA_W/16 words are summed into a 32-bit accumulator.
  - A first beat loads the beat sum rather than adding to the accumulator, so back-to-back packets need no bubble.
- Pipeline, with T the cycle of the last-beat handshake:
  - T+1: fold the end-around carry twice to 16 bits, invert, and swap bytes if SWAP_BYTES. Latch expected and the short flag (beat counter never reached CSUM_BEAT).
  - T+2: compute the verdict; match = !short && expected == computed. Attempt the FIFO write. Pulse pkt_err if !match. Update counters.
  - T+3: m_res_valid is high if the FIFO was empty before the write.
- Result FIFO:
  - First-word-fall-through; outputs are stable while m_res_valid is high and m_res_ready is low.
  - Pop on valid and ready.
  - Full with a simultaneous pop: the write is accepted and nothing is dropped.
  - Full without a pop: the verdict is dropped and drop_cnt is incremented. good_cnt or bad_cnt and pkt_err still update.
  - Empty with a simultaneous write: the result appears the next cycle; no bypass.
- Counters:
  - Saturate at all-ones.
  - clr_cnt wins over a same-cycle increment; the result is 0.
- Checksum arithmetic is byte-order agnostic, so swapping at the end is exact.

Decomposition:
- Package csum_pkg holds:
  - function csum_fold(32 bits -> 16 bits, double end-around carry);
  - function byte_swap16;
  - typedef csum_result_t {match, short, expected, computed}, packed and 34 bits;
  - localparams LANES = DATA_W/16 and BEAT_CNT_W = $clog2(CSUM_BEAT+2).
- One sub-module, csum_result_fifo: a parametrised synchronous FWFT FIFO of csum_result_t with full/empty flags and simultaneous push/pop on full.

Test Plan:
All cases use default parameters unless stated.
1. 7-beat packet, all data zero, keep all ones, beat 6 lane 1 = 0xFFFF -> computed 0xFFFF, match=1, short=0, m_res_valid rises at T+3, good_cnt=1, no pkt_err.
2. 7-beat packet, beat 0 = 64'h1, others zero, expected 0xFEFF -> computed ~0x0001=0xFFFE, swapped 0xFEFF, match=1. Repeat with expected 0xFFFE -> match=0, pkt_err high exactly one cycle at T+2, bad_cnt=1.
3. 3-beat packet with last on beat 2 -> short=1, match=0, expected=0, bad_cnt=1. Immediately follow with the case 1 packet, no gap -> second verdict match=1.
4. Keep masking: 7 beats, beat 0 = 64'hFFFF_FFFF_FFFF_FFFF, keep 8'h01, beat 6 lane 1 = 0xFFFF, all other data zero -> only byte 0x FF summed; computed ~0x00FF=0xFF00, swapped 0x00FF, expected 0xFFFF -> match=0, bad_cnt=1.
5. Hold m_res_ready=0 and send 18 matching packets -> the FIFO holds 16, drop_cnt=2, good_cnt=18. Then raise m_res_ready -> 16 pops in order, then m_res_valid=0.
6. Assert areset on beat 4 of a packet, send clean case 1 packet -> only one result (match=1) and all counters reset then good_cnt=1. clr_cnt during a good verdict's T+2 -> good_cnt=0.
